muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width (>=4, even).
REQ-002 SHALL have port: clk  in  1  rising-edge clock for all state.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  in  1  request; sampled only in IDLE.
REQ-005 SHALL have port: op  in  2  00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU.
REQ-006 SHALL have port: a  in  WIDTH  multiplicand/dividend, captured with start.
REQ-007 SHALL have port: b  in  WIDTH  multiplier/divisor, captured with start.
REQ-008 SHALL have port: busy  out  1  high from the cycle after start acceptance until done.
REQ-009 SHALL have port: done  out  1  one-cycle pulse when hi/lo become valid.
REQ-010 SHALL have port: hi  out  WIDTH  product upper half / remainder.
REQ-011 SHALL have port: lo  out  WIDTH  product lower half / quotient.
REQ-012 SHALL have port: div_zero  out  1  set with done when a divide had b==0; cleared on next acceptance.

Function
REQ-013 SHALL implement FSM IDLE -> PREP -> RUN -> FIX -> IDLE.
REQ-014 IDLE with start=1 SHALL latch a, b, op and go to PREP; start while not IDLE SHALL be ignored.
REQ-015 PREP SHALL take operand magnitudes for signed ops (unsigned ops pass through) and record result signs.
REQ-016 RUN SHALL process exactly one bit per cycle for WIDTH cycles using an internal counter, 0..WIDTH-1.
REQ-017 Multiply SHALL use shift-add on a 2*WIDTH accumulator; hi = product[2W-1:W], lo = product[W-1:0].
REQ-018 Divide SHALL use restoring shift-subtract; lo = quotient, hi = remainder.
REQ-019 FIX SHALL negate product if operand signs differ (signed MULT); for signed DIV negate quotient if signs differ, remainder takes sign of dividend.
REQ-020 done SHALL pulse in the FIX->IDLE cycle: WIDTH+2 cycles after the accepting edge; hi/lo update in that same edge.
REQ-021 DIV/DIVU with b==0 SHALL skip RUN (PREP -> FIX): hi = a, lo = all ones, div_zero=1, done 2 cycles after acceptance.
REQ-022 Signed DIV of most-negative by -1 SHALL give lo = most-negative, hi = 0, div_zero=0.
REQ-023 hi, lo, div_zero SHALL hold until the next done; a new start SHALL be accepted in the cycle after done (back-to-back).
REQ-024 Signed arithmetic SHALL be exact for all inputs including most-negative operands (magnitude held in WIDTH+1 bits where needed).

Reset
REQ-025 rst low SHALL asynchronously force IDLE, counter 0, busy 0, done 0, div_zero 0, hi 0, lo 0, clear internal registers.
REQ-026 Reset asserted mid-operation SHALL abort it with no done pulse; first start after release SHALL behave as from power-up.

Structure
REQ-027 Package muldiv_pkg SHALL hold op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and FSM state enum.
REQ-028 Combinational sub-module muldiv_negate (conditional two's-complement, parameter WIDTH) SHALL serve PREP and FIX.
REQ-029 Single always_ff for state/datapath; no multiplier or divider operators in RTL.

Verification (WIDTH=32)
REQ-030 MULT a=-3, b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB, done exactly 34 cycles after accepting edge, busy high 33 cycles.
REQ-031 MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; MULT a=b=0x80000000 -> hi=0x40000000, lo=0.
REQ-032 DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=100, b=7 -> lo=14, hi=2.
REQ-033 DIVU a=100, b=0 -> div_zero=1, hi=0x64, lo=0xFFFFFFFF, done 2 cycles after acceptance; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
REQ-034 start pulsed during RUN -> ignored, result of first op unchanged; start in cycle after done -> accepted, correct second result.
REQ-035 rst low at RUN cycle 10 -> all outputs 0 immediately, no done; subsequent MULTU 6*7 -> lo=42, hi=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit: operation
// encodings, controller state encoding and small op-decoding helpers.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_RUN  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  // True for the two's-complement variants (operands and results carry a sign).
  function automatic logic op_is_signed(input logic [1:0] o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

  // True for divide operations, false for multiplies.
  function automatic logic op_is_div(input logic [1:0] o);
    return !((o == OP_MULT) || (o == OP_MULTU));
  endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement: passes the value through, or negates it when
// i_neg is set. Used for operand magnitudes and for result sign correction.
module muldiv_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + {{(WIDTH-1){1'b0}}, 1'b1}) : i_val;

endmodule

// File: rtl/muldiv_seq.sv
// Sequential radix-2 multiply/divide unit. Signed operations work on operand
// magnitudes and fix the result signs at the end, so most-negative operands
// are handled exactly (their magnitude fits an unsigned WIDTH-bit value).
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_a, r_b, r_ma, r_mb;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_neg_res, r_neg_rem, r_dz;
  logic               r_busy, r_done, r_div_zero;
  logic [WIDTH-1:0]   r_hi, r_lo;

  logic               w_signed, w_div;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_trial;
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;

  assign w_signed = op_is_signed(r_op);
  assign w_div    = op_is_div(r_op);

  // Operand magnitudes (unsigned ops pass straight through).
  muldiv_negate #(.WIDTH(WIDTH)) u_neg_a (
    .i_val(r_a), .i_neg(w_signed & r_a[WIDTH-1]), .o_val(w_mag_a));
  muldiv_negate #(.WIDTH(WIDTH)) u_neg_b (
    .i_val(r_b), .i_neg(w_signed & r_b[WIDTH-1]), .o_val(w_mag_b));

  // Shift-add step: acc = {partial product, remaining multiplier bits}.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                    + (r_acc[0] ? {1'b0, r_ma} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring divide step: acc = {partial remainder, dividend/quotient bits}.
  // The trial remainder needs one extra bit; after a successful subtract the
  // result is below the divisor, so the low WIDTH bits of the difference are exact.
  assign w_trial    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_ge       = (w_trial >= {1'b0, r_mb});
  assign w_diff     = w_trial[WIDTH-1:0] - r_mb;
  assign w_div_next = {(w_ge ? w_diff : w_trial[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};

  // Result sign correction.
  muldiv_negate #(.WIDTH(2*WIDTH)) u_neg_prod (
    .i_val(r_acc), .i_neg(r_neg_res), .o_val(w_prod_fix));
  muldiv_negate #(.WIDTH(WIDTH)) u_neg_quo (
    .i_val(r_acc[WIDTH-1:0]), .i_neg(r_neg_res), .o_val(w_quo_fix));
  muldiv_negate #(.WIDTH(WIDTH)) u_neg_rem (
    .i_val(r_acc[2*WIDTH-1:WIDTH]), .i_neg(r_neg_rem), .o_val(w_rem_fix));

  // Controller and datapath: accept, prepare magnitudes, iterate, fix signs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= {CW{1'b0}};
      r_op       <= 2'b00;
      r_a        <= {WIDTH{1'b0}};
      r_b        <= {WIDTH{1'b0}};
      r_ma       <= {WIDTH{1'b0}};
      r_mb       <= {WIDTH{1'b0}};
      r_acc      <= {(2*WIDTH){1'b0}};
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_dz       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= {WIDTH{1'b0}};
      r_lo       <= {WIDTH{1'b0}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a        <= a;
            r_b        <= b;
            r_op       <= op;
            r_busy     <= 1'b1;
            r_div_zero <= 1'b0;
            r_state    <= ST_PREP;
          end
        end
        ST_PREP: begin
          r_ma      <= w_mag_a;
          r_mb      <= w_mag_b;
          r_neg_res <= w_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
          r_neg_rem <= w_signed & r_a[WIDTH-1];
          r_cnt     <= {CW{1'b0}};
          if (w_div && (r_b == {WIDTH{1'b0}})) begin
            // Divide by zero: no iterations, fixed result in FIX.
            r_dz    <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_FIX;
          end else begin
            r_dz    <= 1'b0;
            r_acc   <= {{WIDTH{1'b0}}, (w_div ? w_mag_a : w_mag_b)};
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_acc <= w_div ? w_div_next : w_mul_next;
          if (r_cnt == LAST) begin
            r_cnt   <= {CW{1'b0}};
            r_busy  <= 1'b0;
            r_state <= ST_FIX;
          end else begin
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        ST_FIX: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
          if (r_dz) begin
            r_hi       <= r_a;
            r_lo       <= {WIDTH{1'b1}};
            r_div_zero <= 1'b1;
          end else if (w_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            {r_hi, r_lo} <= w_prod_fix;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign div_zero = r_div_zero;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq (WIDTH=32): the driver queues the expected
// result, latency and busy length per accepted operation; the monitor checks
// each done pulse against the head of the queue.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    int          busy_c;
    int          acc;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   busy_cnt = 0;
  int   next_id  = 0;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s (op #%0d): got 0x%08h, expected 0x%08h", nm, id, act, expv);
    end
  endtask

  // Drive one request; caller is positioned away from the rising edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eh, input logic [31:0] el, input logic ed,
                       input int lat, input int bc, input bit push);
    exp_t e;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      e.hi = eh; e.lo = el; e.dz = ed; e.lat = lat; e.busy_c = bc;
      e.acc = cyc; e.id = next_id;
      next_id++;
      sb.push_back(e);
    end
  endtask

  task automatic wait_drain();
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL timeout: %0d results still pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_done();
    int k = 0;
    while (done !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (done !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: done=%b, expected 1", done);
    end
  endtask

  // Monitor: compare every done pulse against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy_cnt = 0;
      end else if (done === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_done: done=1 with no operation outstanding, expected 0");
        end else begin
          e = sb.pop_front();
          chk("hi", e.id, hi, e.hi);
          chk("lo", e.id, lo, e.lo);
          chk("div_zero", e.id, {31'd0, div_zero}, {31'd0, e.dz});
          chk("latency", e.id, cyc - e.acc, e.lat);
          chk("busy_cycles", e.id, busy_cnt, e.busy_c);
        end
        busy_cnt = 0;
      end else if (busy === 1'b1) begin
        busy_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", -1, {31'd0, busy}, 32'd0);
    chk("rst_done", -1, {31'd0, done}, 32'd0);
    chk("rst_hi", -1, hi, 32'd0);
    chk("rst_lo", -1, lo, 32'd0);
    chk("rst_dz", -1, {31'd0, div_zero}, 32'd0);
    @(negedge clk); rst = 1'b1;

    // Directed vectors: op, a, b, hi, lo, div_zero, latency, busy cycles.
    @(negedge clk); issue(2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34, 33, 1'b1); wait_drain();
    @(negedge clk); issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34, 33, 1'b1); wait_drain();
    @(negedge clk); issue(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34, 33, 1'b1); wait_drain();
    @(negedge clk); issue(2'b00, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0, 34, 33, 1'b1); wait_drain();
    @(negedge clk); issue(2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, 33, 1'b1); wait_drain();
    @(negedge clk); issue(2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34, 33, 1'b1); wait_drain();
    @(negedge clk); issue(2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 34, 33, 1'b1); wait_drain();
    @(negedge clk); issue(2'b11, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1, 2,  1,  1'b1); wait_drain();
    @(negedge clk); issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34, 33, 1'b1); wait_drain();
    @(negedge clk); issue(2'b10, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 2,  1,  1'b1); wait_drain();

    // start pulsed during RUN must be ignored.
    @(negedge clk); issue(2'b11, 32'd1000, 32'd10, 32'd0, 32'd100, 1'b0, 34, 33, 1'b1);
    repeat (8) @(negedge clk);
    issue(2'b01, 32'd3, 32'd3, 32'd0, 32'd0, 1'b0, 0, 0, 1'b0);
    wait_drain();

    // Back-to-back: second start in the cycle right after done.
    @(negedge clk); issue(2'b01, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, 34, 33, 1'b1);
    wait_done();
    issue(2'b10, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0, 34, 33, 1'b1);
    wait_drain();

    // Reset in RUN cycle 10: outputs clear at once, no done follows.
    @(negedge clk); issue(2'b00, 32'd12345, 32'd2, 32'd0, 32'd0, 1'b0, 0, 0, 1'b0);
    repeat (11) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("abort_busy", -1, {31'd0, busy}, 32'd0);
    chk("abort_done", -1, {31'd0, done}, 32'd0);
    chk("abort_hi", -1, hi, 32'd0);
    chk("abort_lo", -1, lo, 32'd0);
    chk("abort_dz", -1, {31'd0, div_zero}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    issue(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 34, 33, 1'b1);
    wait_drain();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
